// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
//  mm_pkg
//  Shared state encoding and address helpers for the matrix-multiply tile
//  controller.
//  Revision: 1.0
// ============================================================================
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_B = 3'd1,
        LOAD_A = 3'd2,
        LAUNCH = 3'd3,
        WAIT   = 3'd4,
        EMIT   = 3'd5,
        DONE   = 3'd6
    } mm_state_e;

    localparam int unsigned MM_DEF_MATSIZE = 16;
    localparam int unsigned MM_DEF_LANES   = 4;

    function automatic int unsigned mm_sq(input int unsigned n);
        return n * n;
    endfunction

    function automatic int unsigned mm_groups(input int unsigned n, input int unsigned lanes);
        return n / lanes;
    endfunction

    // N is a power of two, so (k mod N)*N + k/N is a swap of the two index fields.
    function automatic logic [31:0] mm_tr_addr(input logic [31:0] k, input int unsigned log2n);
        logic [31:0] mask;
        mask = (32'd1 << log2n) - 32'd1;
        return ((k & mask) << log2n) | (k >> log2n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_addr_gen.sv
`default_nettype none
// ============================================================================
//  mm_addr_gen
//  Beat counters and cache write-address mux: B stored transposed, A row
//  placed after the N*N B block.
//  Revision: 1.0
// ============================================================================
import mm_pkg::*;

module mm_addr_gen #(
    parameter int MATSIZE = MM_DEF_MATSIZE,
    parameter int ADRW    = $clog2(MATSIZE*MATSIZE+MATSIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  mm_state_e       state,
    input  logic            beat,
    output logic            last_b,
    output logic            last_a,
    output logic [ADRW-1:0] wr_addr
);

    localparam int unsigned    c_log2n  = $clog2(MATSIZE);
    localparam int unsigned    c_kw     = 2 * c_log2n;
    localparam logic [ADRW-1:0] c_a_base = ADRW'(mm_sq(MATSIZE));

    logic [c_kw-1:0]    r_k;
    logic [c_log2n-1:0] r_j;

    // Counters are exactly sized, so they return to zero after the last beat.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            r_k <= '0;
            r_j <= '0;
        end else begin
            if (state == LOAD_B && beat) r_k <= r_k + 1'b1;
            if (state == LOAD_A && beat) r_j <= r_j + 1'b1;
        end
    end

    assign last_b = (r_k == '1);
    assign last_a = (r_j == '1);

    always_comb begin
        wr_addr = '0;
        case (state)
            LOAD_B:  wr_addr = ADRW'(mm_tr_addr(32'(r_k), c_log2n));
            LOAD_A:  wr_addr = c_a_base + ADRW'(r_j);
            default: wr_addr = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mm_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  mm_tile_ctrl
//  Sequencer for an N x N multiply over LANES MAC lanes. Optional job cycle
//  counter enabled by MM_TILE_CTRL_PERF_EN.
//  Revision: 1.0
// ============================================================================
import mm_pkg::*;

module mm_tile_ctrl #(
    parameter int MATSIZE = MM_DEF_MATSIZE,
    parameter int LANES   = MM_DEF_LANES,
    parameter int ADRW    = $clog2(MATSIZE*MATSIZE+MATSIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             wr_en,
    output logic [ADRW-1:0]  wr_addr,
    output logic             mul_start,
    output logic [ADRW-1:0]  b_base,
    input  logic [LANES-1:0] lane_done,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_intr,
    output logic             busy,
    output logic [31:0]      perf_cycles
);

    localparam int              c_groups     = mm_groups(MATSIZE, LANES);
    localparam int              c_rw         = $clog2(MATSIZE);
    localparam int              c_gw         = (c_groups > 1) ? $clog2(c_groups) : 1;
    localparam logic [ADRW-1:0] c_grp_stride = ADRW'(LANES * MATSIZE);
    localparam logic [c_gw-1:0] c_g_last     = c_gw'(c_groups - 1);
    localparam logic [c_rw-1:0] c_r_last     = c_rw'(MATSIZE - 1);

    mm_state_e        r_state;
    logic [c_rw-1:0]  r_row;
    logic [c_gw-1:0]  r_grp;
    logic             w_beat;
    logic             w_last_b;
    logic             w_last_a;

    assign s_ready   = (r_state == LOAD_B) || (r_state == LOAD_A);
    assign w_beat    = s_valid && s_ready;
    assign wr_en     = w_beat;
    assign mul_start = (r_state == LAUNCH);
    assign b_base    = mul_start ? ADRW'(r_grp) * c_grp_stride : '0;
    assign o_valid   = (r_state == EMIT);
    assign o_intr    = (r_state == DONE);
    assign busy      = (r_state != IDLE);

    mm_addr_gen #(
        .MATSIZE (MATSIZE),
        .ADRW    (ADRW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .state   (r_state),
        .beat    (w_beat),
        .last_b  (w_last_b),
        .last_a  (w_last_a),
        .wr_addr (wr_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_grp   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= LOAD_B;
                    r_row   <= '0;
                    r_grp   <= '0;
                end
                LOAD_B: if (w_beat && w_last_b) r_state <= LOAD_A;
                LOAD_A: if (w_beat && w_last_a) begin
                    r_grp   <= '0;
                    r_state <= LAUNCH;
                end
                LAUNCH: r_state <= WAIT;
                // A group completes only when every lane reports done in the same cycle.
                WAIT: if (&lane_done) begin
                    if (r_grp != c_g_last) begin
                        r_grp   <= r_grp + 1'b1;
                        r_state <= LAUNCH;
                    end else begin
                        r_state <= EMIT;
                    end
                end
                EMIT: if (o_ready) begin
                    if (r_row != c_r_last) begin
                        r_row   <= r_row + 1'b1;
                        r_state <= LOAD_A;
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MM_TILE_CTRL_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (r_state == IDLE && start) begin
            r_perf <= '0;
        end else if (busy && r_perf != 32'hFFFF_FFFF) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mm_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_mm_tile_ctrl
//  Directed bench for mm_tile_ctrl at MATSIZE=4, LANES=2.
//  Revision: 1.0
// ============================================================================
module tb_mm_tile_ctrl;

    localparam int AW = 5;
`ifdef MM_TILE_CTRL_PERF_EN
    localparam int EXP_PERF = 69;
`else
    localparam int EXP_PERF = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          mul_start;
    logic [AW-1:0] b_base;
    logic [1:0]    lane_done;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic          o_intr;
    logic          busy;
    logic [31:0]   perf_cycles;

    logic          resp_en = 1'b0;
    logic [1:0]    tab_ld = 2'b00;
    logic [1:0]    resp_ld = 2'b00;
    int            resp_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    assign lane_done = resp_en ? resp_ld : tab_ld;

    always #5 clk = ~clk;

    mm_tile_ctrl #(.MATSIZE(4), .LANES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .mul_start(mul_start), .b_base(b_base),
        .lane_done(lane_done), .o_valid(o_valid), .o_ready(o_ready), .o_intr(o_intr),
        .busy(busy), .perf_cycles(perf_cycles)
    );

    // Lane model: all lanes report done three cycles after each launch.
    always @(negedge clk) begin
        if (mul_start) begin
            resp_cnt <= 3;
            resp_ld  <= 2'b00;
        end else if (resp_cnt != 0) begin
            resp_cnt <= resp_cnt - 1;
            if (resp_cnt == 1) resp_ld <= 2'b11;
        end
    end

    typedef struct packed {
        logic        st;
        logic        sv;
        logic        ordy;
        logic [1:0]  ld;
        logic [14:0] exp;   // {s_ready, wr_en, wr_addr, mul_start, b_base, o_valid, busy}
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic st, input logic sv, input logic ordy, input logic [1:0] ld,
                       input logic srdy, input logic wen, input logic [4:0] addr,
                       input logic ms, input logic [4:0] base, input logic ov);
        vec_t v;
        v.st = st; v.sv = sv; v.ordy = ordy; v.ld = ld;
        v.exp = {srdy, wen, addr, ms, base, ov, 1'b1};
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {s_ready, wr_en, wr_addr, mul_start, b_base, o_valid, o_intr, busy, perf_cycles}, 64'd0);
    endtask

    initial begin
        int b_addr [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
        int rows, ms_cnt, intr_cnt, intr_cyc, found;
        logic done_loop;

        // B load (start pulse in beat 5 is ignored), stray lane_done in LOAD_A.
        for (int c = 0; c < 16; c++) add(c == 5, 1, 0, 2'b00, 1, 1, 5'(b_addr[c]), 0, 0, 0);
        for (int j = 0; j < 4; j++)  add(0, 1, 0, (j == 1) ? 2'b11 : 2'b00, 1, 1, 5'(16 + j), 0, 0, 0);
        add(0, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0);                                       // LAUNCH g=0
        for (int c = 0; c < 5; c++)  add(0, 0, c == 1, 2'b01, 0, 0, 0, 0, 0, 0);    // partial done
        add(0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0);                                       // full done
        add(0, 0, 0, 2'b00, 0, 0, 0, 1, 8, 0);                                       // LAUNCH g=1
        add(0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 1);         // EMIT stall
        add(0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 1);                                       // row accepted
        add(0, 1, 0, 2'b00, 1, 1, 16, 0, 0, 0);
        add(0, 1, 0, 2'b00, 1, 1, 17, 0, 0, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset_state");

        start = 1'b1; s_valid = 1'b1;
        #1 chk("idle_ignores_s_valid", {s_ready, wr_en, busy}, 3'b000);
        @(negedge clk);
        foreach (tv[i]) begin
            start = tv[i].st; s_valid = tv[i].sv; o_ready = tv[i].ordy; tab_ld = tv[i].ld;
            #1;
            chk($sformatf("vec[%0d]", i), {s_ready, wr_en, wr_addr, mul_start, b_base, o_valid, busy}, tv[i].exp);
            @(negedge clk);
        end

        // Full job with the lane model and no stalls.
        rst = 1'b1; start = 1'b0; o_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; resp_en = 1'b1;
        @(negedge clk);
        start = 1'b1; s_valid = 1'b1; o_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rows = 0; ms_cnt = 0; intr_cnt = 0; intr_cyc = -1; done_loop = 1'b0;
        for (int cyc = 0; cyc < 300 && !done_loop; cyc++) begin
            if (!busy) begin
                done_loop = 1'b1;
            end else begin
                if (mul_start) begin
                    chk($sformatf("b_base[%0d]", ms_cnt), b_base, (ms_cnt % 2 == 0) ? 0 : 8);
                    ms_cnt++;
                end
                if (o_valid && o_ready) rows++;
                if (o_intr) begin intr_cnt++; intr_cyc = cyc; end
                @(negedge clk);
            end
        end
        chk("job_finished", done_loop, 1);
        chk("mul_start_count", ms_cnt, 8);
        chk("row_count", rows, 4);
        chk("intr_count", intr_cnt, 1);
        chk("intr_cycle", intr_cyc, 68);
        chk("perf_cycles", perf_cycles, EXP_PERF);
        repeat (3) @(negedge clk);
        chk("perf_hold_idle", perf_cycles, EXP_PERF);

        // Reset during WAIT of row 2 aborts the job.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rows = 0; found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            if (o_valid && o_ready) rows++;
            else if (mul_start && rows == 2) found = 1;
            if (found == 0) @(negedge clk);
        end
        chk("reach_row2_launch", found, 1);
        @(negedge clk);
        chk("row2_wait", {busy, mul_start, o_valid}, 3'b100);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_job_reset");
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_first_beat", {busy, wr_en, wr_addr}, {2'b11, 5'd0});
        @(negedge clk);
        chk("restart_second_beat", {wr_en, wr_addr}, {1'b1, 5'd4});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mm_tile_ctrl.md
Name: mm_tile_ctrl

Overview:
- Parametrised successor controller for the PL matrix-multiply engine. It sequences an N×N multiply of A×B over a bank of LANES MAC lanes.
- Accepts an AXI-Stream-style input: matrix B first (row-major), then matrix A one row per pass.
- Generates cache-buffer write addresses, with B stored transposed.
- Issues lane-group multiply starts, collects lane completion flags, and presents one output-row handshake per A row.
- Raises a completion interrupt when all N rows are done.

Parameters:
- MATSIZE, 16, matrix dimension N. Power of two, ≥ 4.
- LANES, 4, number of parallel MAC lanes. Must divide MATSIZE.
- ADRW, $clog2(MATSIZE*MATSIZE+MATSIZE), cache address width. Derived; not overridden.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a job. Ignored unless in IDLE.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- wr_en  out  1  cache write strobe, asserted on the same cycle as the accepted beat (combinational from handshake).
- wr_addr  out  ADRW  cache write address.
- mul_start  out  1  one-cycle pulse that launches a lane group.
- b_base  out  ADRW  base address of B^T rows for the launched group.
- lane_done  in  LANES  per-lane done level, sampled synchronously.
- o_valid  out  1  one output row is ready in the lane result buffer.
- o_ready  in  1  downstream accepts the row.
- o_intr  out  1  one-cycle pulse on job completion.
- busy  out  1  high in any state other than IDLE.
- perf_cycles  out  32  job cycle count (see Optional Feature).

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-job aborts the job immediately; the next job requires a new start.
- States: IDLE → LOAD_B → LOAD_A → LAUNCH → WAIT → EMIT → (LOAD_A | DONE) → IDLE.
- IDLE:
  - s_ready = 0.
  - start → LOAD_B, beat counter k = 0, row counter r = 0.
- LOAD_B:
  - s_ready = 1.
  - Each accepted beat k (0..N²-1) writes wr_addr = (k mod N)*N + k/N, i.e. the transpose.
  - After beat N²-1: k = 0, go to LOAD_A.
- LOAD_A:
  - s_ready = 1.
  - Beat j (0..N-1) writes wr_addr = N² + j.
  - After beat N-1: group counter g = 0, go to LAUNCH.
- LAUNCH:
  - s_ready = 0.
  - Pulse mul_start for exactly one cycle with b_base = g*LANES*N, then go to WAIT.
- WAIT:
  - Stay until lane_done == all ones in a single sampled cycle.
  - Then, if g < N/LANES-1: g++ and go to LAUNCH. Otherwise go to EMIT.
  - lane_done is ignored in every other state.
- EMIT:
  - o_valid = 1, held stable until o_ready is sampled high.
  - On o_valid && o_ready: if r < N-1, r++ and go to LOAD_A; else go to DONE.
- DONE:
  - o_intr = 1 for one cycle, then go to IDLE.
- Timing and boundaries:
  - Latency from the last A beat to mul_start is 1 cycle.
  - Back-to-back groups are separated by the 1-cycle LAUNCH→WAIT gap.
  - s_valid outside the LOAD states is ignored and produces no wr_en.
  - start while busy is ignored.
  - o_ready high before o_valid has no effect.
  - Counters are sized exactly. There is no wrap-around beyond N²-1, N-1 or N/LANES-1.

Optional Feature:
- Macro: MM_TILE_CTRL_PERF_EN.
- Defined:
  - perf_cycles clears on an accepted start.
  - It increments every cycle while busy, saturating at 2³²-1.
  - It holds its value in IDLE until the next start.
- Undefined: perf_cycles is tied to 0. No counter logic is instantiated.

Decomposition:
- Package mm_pkg holds:
  - state enum mm_state_e {IDLE, LOAD_B, LOAD_A, LAUNCH, WAIT, EMIT, DONE};
  - localparams for the N², N and group-count arithmetic;
  - the transposed-address function.
- One natural sub-module: mm_addr_gen. It owns k, j and the wr_addr mux, driven by the state and the handshake.

Test Plan:
- MATSIZE=4, LANES=2: start, then 16 B beats with s_valid held high → wr_addr sequence 0,4,8,12,1,5,…,15; s_ready drops after beat 15 only if A has not started (LOAD_A continues at addresses 16..19).
- Full job with lane_done asserted 3 cycles after each mul_start → 2 mul_start pulses per row with b_base 0 then 8; 4 o_valid rows; one o_intr pulse.
- Hold o_ready = 0 for 10 cycles in EMIT → o_valid stays high; no s_ready; state stays EMIT; the row is accepted on the cycle o_ready rises.
- Partial lane_done (0b01 for 5 cycles, then 0b11) → no new mul_start until 0b11; a stray lane_done in LOAD_A has no effect.
- Assert rst during WAIT of row 2 → all outputs 0 next cycle; busy = 0; a subsequent start restarts at wr_addr 0.
- With MM_TILE_CTRL_PERF_EN, stalls disabled, MATSIZE=4 → perf_cycles equals the exact computed job length; without the macro it reads 0.
